// File: rtl/dff_readback_pkg.sv
// -----------------------------------------------------------------------------
// dff_readback_pkg
// Shared definitions for the flop readback serializer.
//   state_t    : FSM state encoding (PAR is only reachable when
//                DFF_READBACK_PARITY_EN is defined).
//   beat_count : number of serial beats emitted per captured word.
// Optional feature macro: DFF_READBACK_PARITY_EN (appends an even-parity beat).
// -----------------------------------------------------------------------------
package dff_readback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    // Beats per capture: one per data bit, plus the parity beat when enabled.
    function automatic int beat_count(input int width);
`ifdef DFF_READBACK_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/dff_readback_serializer.sv
// -----------------------------------------------------------------------------
// dff_readback_serializer
// Captures a WIDTH-bit word of flop outputs into a shadow register on request
// and shifts it out serially, LSB first, so the flop state can be observed on
// a single pin.
//
// Ports:
//   clk        : rising-edge clock
//   clr        : asynchronous active-high reset
//   cap_req    : capture request, honoured only while idle
//   par_in     : parallel word, sampled only on the capture edge
//   en         : downstream accept
//   sout       : current serial bit
//   sout_valid : sout holds a valid beat
//   sout_last  : current beat is the final beat of the word
//   busy       : a word is being shifted out
//
// Handshake: a beat transfers on a rising clk edge where sout_valid and en are
// both 1; while en is 0 the current beat (sout, sout_last) holds indefinitely.
//
// Optional feature macro: DFF_READBACK_PARITY_EN. When defined, one extra beat
// carrying the even parity (XOR) of the captured word follows the data bits,
// and sout_last marks that parity beat instead of the last data bit.
// -----------------------------------------------------------------------------
module dff_readback_serializer
    import dff_readback_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cap_req,
    input  logic [WIDTH-1:0] par_in,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    // The counter holds "beats remaining after the current one", so the final
    // beat is always count == 0 whether or not the parity beat is present.
    localparam int               BEATS    = beat_count(WIDTH);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(BEATS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;
`ifdef DFF_READBACK_PARITY_EN
    logic             par_q, par_d;
`endif

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            count_q  <= '0;
`ifdef DFF_READBACK_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
`ifdef DFF_READBACK_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // ------------------------------------------------- next state / datapath
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        count_d  = count_q;
`ifdef DFF_READBACK_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                // Requests are only seen here, so a request while busy (or on
                // the final transfer edge) is dropped rather than queued.
                if (cap_req) begin
                    shadow_d = par_in;
                    count_d  = LOAD_CNT;
`ifdef DFF_READBACK_PARITY_EN
                    par_d    = ^par_in;
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    shadow_d = shadow_q >> 1;
                    if (count_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - CNT_W'(1);
`ifdef DFF_READBACK_PARITY_EN
                        // One beat left after this one: it is the parity beat.
                        if (count_q == CNT_W'(1)) begin
                            state_d = PAR;
                        end
`endif
                    end
                end
            end
`ifdef DFF_READBACK_PARITY_EN
            PAR: begin
                if (en) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------- outputs
    // Decoded from registers only; clr clears the registers, so the outputs
    // drop as soon as clr rises.
    always_comb begin
        busy       = (state_q != IDLE);
        sout_valid = busy;
        sout_last  = busy && (count_q == '0);
        sout       = 1'b0;
        if (state_q == SHIFT) begin
            sout = shadow_q[0];
        end
`ifdef DFF_READBACK_PARITY_EN
        else if (state_q == PAR) begin
            sout = par_q;
        end
`endif
    end

endmodule

// File: tb/tb_dff_readback_serializer.sv
// -----------------------------------------------------------------------------
// tb_dff_readback_serializer
// Bench for dff_readback_serializer with two instances: WIDTH=8 and WIDTH=1.
// A queue model holds the beats still owed by each instance; it is compared
// with the outputs on every falling edge. Directed scenarios add literal
// expectations on the serial words actually transferred.
// Honours DFF_READBACK_PARITY_EN for the expected beat count and parity beat.
// -----------------------------------------------------------------------------
module tb_dff_readback_serializer;
    import dff_readback_pkg::*;

    localparam int N8 = beat_count(8);
    localparam int N1 = beat_count(1);

    // ------------------------------------------------------- clock / reset
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic       cap_req8, en8, sout8, sout_valid8, sout_last8, busy8;
    logic [7:0] par8;
    logic       cap_req1, en1, sout1, sout_valid1, sout_last1, busy1;
    logic [0:0] par1;

    dff_readback_serializer #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .clr        (clr),
        .cap_req    (cap_req8),
        .par_in     (par8),
        .en         (en8),
        .sout       (sout8),
        .sout_valid (sout_valid8),
        .sout_last  (sout_last8),
        .busy       (busy8)
    );

    dff_readback_serializer #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .clr        (clr),
        .cap_req    (cap_req1),
        .par_in     (par1),
        .en         (en1),
        .sout       (sout1),
        .sout_valid (sout_valid1),
        .sout_last  (sout_last1),
        .busy       (busy1)
    );

    // ------------------------------------------------------------- scoring
    int checks   = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // --------------------------------------------------------------- model
    // Each queue lists the beats a capture still owes, front = current beat.
    // A request is accepted only on an edge where nothing is owed.
    logic [0:0] exp8_q[$];
    logic [0:0] exp1_q[$];

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            exp8_q.delete();
            exp1_q.delete();
        end else begin
            if (exp8_q.size() != 0) begin
                if (en8) void'(exp8_q.pop_front());
            end else if (cap_req8) begin
                for (int i = 0; i < 8; i++) exp8_q.push_back(par8[i]);
`ifdef DFF_READBACK_PARITY_EN
                exp8_q.push_back(^par8);
`endif
            end
            if (exp1_q.size() != 0) begin
                if (en1) void'(exp1_q.pop_front());
            end else if (cap_req1) begin
                exp1_q.push_back(par1[0]);
`ifdef DFF_READBACK_PARITY_EN
                exp1_q.push_back(^par1);
`endif
            end
        end
    end

    // Compare process: every falling edge, all outputs of both instances.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("sout_valid8", 32'(sout_valid8), 32'(exp8_q.size() != 0));
            chk("sout8",       32'(sout8),       32'((exp8_q.size() != 0) ? exp8_q[0] : 1'b0));
            chk("sout_last8",  32'(sout_last8),  32'(exp8_q.size() == 1));
            chk("busy8",       32'(busy8),       32'(exp8_q.size() != 0));
            chk("sout_valid1", 32'(sout_valid1), 32'(exp1_q.size() != 0));
            chk("sout1",       32'(sout1),       32'((exp1_q.size() != 0) ? exp1_q[0] : 1'b0));
            chk("sout_last1",  32'(sout_last1),  32'(exp1_q.size() == 1));
            chk("busy1",       32'(busy1),       32'(exp1_q.size() != 0));
        end
    end

    // Record what actually transfers on the WIDTH=8 instance.
    logic [0:0] obs8[$];
    int last_idx = -1;
    int nlast    = 0;

    always @(negedge clk) begin
        if (sout_valid8 === 1'b1 && en8 === 1'b1) begin
            obs8.push_back(sout8);
            if (sout_last8 === 1'b1) begin
                last_idx = obs8.size() - 1;
                nlast++;
            end
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs8.delete();
        last_idx = -1;
        nlast    = 0;
    endtask

    task automatic capture8(input logic [7:0] w);
        cap_req8 = 1'b1;
        par8     = w;
        step();
        cap_req8 = 1'b0;
        par8     = 8'($urandom_range(0, 255));
    endtask

    task automatic capture1(input logic w);
        cap_req1 = 1'b1;
        par1     = w;
        step();
        cap_req1 = 1'b0;
        par1     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle8(input string tag, input int budget);
        int n = 0;
        while ((busy8 !== 1'b0 || exp8_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_idle_in_budget"}, 32'(n < budget), 32'(1));
    endtask

    task automatic run_en_pattern8(input string tag, input logic [3:0] pat, input int budget);
        int c = 0;
        while ((busy8 !== 1'b0 || exp8_q.size() != 0) && c < budget) begin
            en8 = pat[c[1:0]];
            step();
            c++;
        end
        en8 = 1'b1;
        chk({tag, "_idle_in_budget"}, 32'(c < budget), 32'(1));
    endtask

    task automatic check_word8(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = '0;
        for (int i = 0; i < obs8.size() && i < 9; i++) got = got | (9'(obs8[i]) << i);
        chk({tag, "_bits"},  32'(got),         32'(exp));
        chk({tag, "_beats"}, 32'(obs8.size()), 32'(N8));
        chk({tag, "_lastix"}, 32'(last_idx),   32'(N8 - 1));
        chk({tag, "_nlast"}, 32'(nlast),       32'(1));
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        cap_req8 = 1'b0; par8 = '0; en8 = 1'b0;
        cap_req1 = 1'b0; par1 = '0; en1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr    = 1'b0;
        chk_on = 1'b1;

        chk("rst_sout8",       32'(sout8),       32'(0));
        chk("rst_sout_valid8", 32'(sout_valid8), 32'(0));
        chk("rst_sout_last8",  32'(sout_last8),  32'(0));
        chk("rst_busy8",       32'(busy8),       32'(0));
        chk("rst_sout_valid1", 32'(sout_valid1), 32'(0));
        chk("rst_busy1",       32'(busy1),       32'(0));
        step();

        // A5, en held high: 1,0,1,0,0,1,0,1 starting one cycle after request.
        en8 = 1'b1;
        clear_obs();
        capture8(8'hA5);
        chk("a5_first_valid", 32'(sout_valid8), 32'(1));
        chk("a5_first_bit",   32'(sout8),       32'(1));
        chk("a5_first_busy",  32'(busy8),       32'(1));
        wait_idle8("a5", 40);
        check_word8("a5", 9'h0A5);
        step();

        // A5 with en pattern 1,0,0,1 repeating: beats hold while en=0.
        clear_obs();
        capture8(8'hA5);
        run_en_pattern8("a5_stall", 4'b1001, 80);
        check_word8("a5_stall", 9'h0A5);
        step();

        // Request for FF during the 3rd beat is dropped.
        clear_obs();
        capture8(8'hA5);
        repeat (2) step();
        cap_req8 = 1'b1;
        par8     = 8'hFF;
        step();
        cap_req8 = 1'b0;
        wait_idle8("busy_req", 40);
        check_word8("busy_req", 9'h0A5);
        repeat (12) step();
        chk("busy_req_no_second_word", 32'(obs8.size()), 32'(N8));

        // Request on the edge of the final transfer is dropped too.
        clear_obs();
        capture8(8'hA5);
        repeat (N8 - 1) step();
        cap_req8 = 1'b1;
        par8     = 8'h5A;
        step();
        cap_req8 = 1'b0;
        chk("final_edge_valid", 32'(sout_valid8), 32'(0));
        chk("final_edge_busy",  32'(busy8),       32'(0));
        repeat (4) step();
        check_word8("final_edge", 9'h0A5);

        // clr after 3 transfers: outputs drop before the next clock edge.
        clear_obs();
        capture8(8'hA5);
        repeat (3) step();
        #2;
        clr = 1'b1;
        #1;
        chk("clr_sout_valid", 32'(sout_valid8), 32'(0));
        chk("clr_busy",       32'(busy8),       32'(0));
        chk("clr_sout",       32'(sout8),       32'(0));
        chk("clr_sout_last",  32'(sout_last8),  32'(0));
        step();
        clr = 1'b0;
        chk("clr_partial_beats", 32'(obs8.size()), 32'(3));
        step();
        clear_obs();
        capture8(8'h3C);
        wait_idle8("c3", 40);
        check_word8("c3", 9'h03C);
        step();

        // 07: parity beat (when present) is 1.
        clear_obs();
        capture8(8'h07);
        wait_idle8("w07", 40);
`ifdef DFF_READBACK_PARITY_EN
        check_word8("w07", 9'h107);
`else
        check_word8("w07", 9'h007);
`endif
        step();

        // WIDTH=1 instance.
        en1 = 1'b1;
        capture1(1'b1);
        chk("w1_sout",  32'(sout1),       32'(1));
        chk("w1_valid", 32'(sout_valid1), 32'(1));
        chk("w1_busy",  32'(busy1),       32'(1));
`ifdef DFF_READBACK_PARITY_EN
        chk("w1_last_data", 32'(sout_last1), 32'(0));
        step();
        chk("w1_par_sout", 32'(sout1),      32'(1));
        chk("w1_par_last", 32'(sout_last1), 32'(1));
`else
        chk("w1_last", 32'(sout_last1), 32'(1));
`endif
        step();
        chk("w1_done_valid", 32'(sout_valid1), 32'(0));
        chk("w1_done_busy",  32'(busy1),       32'(0));
        step();
        capture1(1'b0);
        chk("w1_zero_sout",  32'(sout1),       32'(0));
        chk("w1_zero_valid", 32'(sout_valid1), 32'(1));
        repeat (N1 + 2) step();
        chk("w1_zero_done", 32'(sout_valid1), 32'(0));

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dff_readback_serializer.md
Name: dff_readback_serializer

Overview:
- Reader side of a bank of flip-flops. On request it captures a WIDTH-bit parallel word of flop outputs into a shadow register.
- It then shifts the word out serially, LSB first, under a valid/enable handshake.
- It sits beside the flop test structures so their state can be observed through a single pin, or checked by a serial monitor.

Parameters:
- WIDTH, 8, number of captured bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), width of the beat counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset, asynchronous, active-high; forces all state to reset values immediately.
- cap_req  input  1  capture request; sampled on rising clk.
- par_in  input  WIDTH  parallel word from the flops under observation.
- en  input  1  downstream accept; a beat transfers on a rising clk when sout_valid and en are both 1.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid beat.
- sout_last  output  1  current beat is the final one of the word.
- busy  output  1  capture or shift in progress.

Behaviour:
- One clock (clk). Reset (clr) is asynchronous and active-high.
- Reset values: state=IDLE, shadow=0, count=0; outputs sout=0, sout_valid=0, sout_last=0, busy=0.
- All outputs are registered or decoded from registers only. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, SHIFT, and PAR (PAR exists only with the optional feature).
- IDLE, on cap_req=1 at a rising edge:
  - shadow <= par_in and count <= WIDTH-1;
  - next state is SHIFT;
  - busy and sout_valid go high in the following cycle. Latency is 1 clock from the request edge to the first valid beat.
- SHIFT:
  - sout=shadow[0], sout_valid=1, sout_last=(count==0).
  - On a transfer (en=1): shadow shifts right one bit (MSB filled with 0) and count decrements.
  - With en=0, everything holds, including sout, for an unbounded number of cycles.
- Last beat in SHIFT (count==0 and en=1): next state is IDLE, with sout_valid=0, busy=0 and sout=0 on the next cycle. Exactly WIDTH transfers occur per capture.
- cap_req while busy: ignored. It is not queued, and shadow is not disturbed.
- cap_req on the same edge as the final transfer: ignored. The block must see IDLE for at least one cycle before a new capture.
- clr asserted mid-shift: outputs drop immediately (asynchronously) and the word is discarded. After clr deasserts, the next cap_req starts a fresh capture.
- WIDTH=1: the single beat has sout_last=1 on its first valid cycle.
- par_in is sampled only on the capture edge. Changes at any other time have no effect.

Optional Feature:
- Macro: DFF_READBACK_PARITY_EN.
- Defined:
  - after the last data transfer the FSM enters PAR and emits one extra beat, sout = XOR of the captured word (even parity);
  - the parity value is latched at capture;
  - sout_last is asserted on the PAR beat only, not on data bit WIDTH-1;
  - total beats per capture = WIDTH+1; the PAR beat obeys the same en handshake.
- Undefined: the PAR state, the parity register and the parity logic are absent; WIDTH beats per capture.

Decomposition:
- Package dff_readback_pkg holds:
  - the state typedef: enum logic [1:0] {IDLE=2'd0, SHIFT=2'd1, PAR=2'd2};
  - a function computing the beat count (WIDTH, or WIDTH+1 under the macro), used by both RTL and bench.
- No sub-module. The counter, the shift register and the parity reduction are too small to justify one; a single module is required.

Test Plan:
- WIDTH=8, par_in=8'hA5, cap_req one cycle, en held 1 -> sout 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after the request; sout_last only on the 8th beat; busy=0 on the cycle after.
- Same word, en pattern 1,0,0,1,... -> sout holds during en=0; bit order unchanged; exactly 8 transfers.
- cap_req with par_in=8'hFF issued during the 3rd beat of an 8'hA5 word -> A5 sequence completes unchanged; no second word follows.
- clr pulsed after 3 transfers -> sout_valid/busy/sout go 0 in the same cycle without waiting for clk; a later capture of 8'h3C yields 0,0,1,1,1,1,0,0.
- WIDTH=1, par_in=1 -> one beat, sout=1 with sout_valid=1 and sout_last=1, then IDLE.
- With DFF_READBACK_PARITY_EN defined, WIDTH=8:
  - 8'hA5 -> 9 beats, 9th beat sout=0, sout_last on the 9th only;
  - 8'h07 -> 9th beat sout=1.
